attribute_panel_renderer: RTL and testbench

Parametrised attribute-panel pixel source for the HUD. It draws a tiled background from a tile ROM and overlays NUM_CH decimal value strips. Displayed values animate toward their targets once per frame, and each channel flashes when its target changes. It sits beside the map drawer in the draw engine and returns one COLOR_ID per pixel, registered, with a fixed 2-cycle latency.

---
 rtl/attribute_panel_renderer.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_attribute_panel_renderer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/attribute_panel_renderer.sv
// HUD attribute panel: tiled background with NUM_CH animated decimal value strips,
// per-channel flash on target change, and a 2-cycle registered pixel output.
module attribute_panel_renderer #(
  parameter logic [19:0] COOR         = {10'd32, 10'd32},
  parameter int          TILES_X      = 6,
  parameter int          TILES_Y      = 5,
  parameter int          TILE_WIDTH   = 32,
  parameter int          NUM_TILES    = 4,
  parameter int          NUM_CH       = 5,
  parameter int          NUM_DIGIT    = 4,
  parameter int          MAX_VALUE    = 9999,
  parameter int          STEP         = 8,
  parameter int          FLASH_FRAMES = 8,
  parameter int          DIGIT_X0     = 40,
  parameter int          DIGIT_Y0     = 8,
  parameter int          ROW_PITCH    = 32,
  parameter logic [7:0]  DIGIT_COLOR  = 8'd15,
  parameter logic [7:0]  FLASH_COLOR  = 8'd12
) (
  input  logic                    CLK,
  input  logic                    RESET_H,
  input  logic                    FRAME_CLK,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  input  logic [NUM_CH-1:0][13:0] ValueArr,
  output logic [7:0]              COLOR_ID
);

  localparam int PANEL_W   = TILES_X * TILE_WIDTH;
  localparam int PANEL_H   = TILES_Y * TILE_WIDTH;
  localparam int TW_BITS   = $clog2(TILE_WIDTH);
  localparam int ROM_DEPTH = NUM_TILES * TILE_WIDTH * TILE_WIDTH;
  localparam int ADDR_W    = $clog2(ROM_DEPTH);
  localparam int BCD_W     = 4 * NUM_DIGIT;
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FL_W      = $clog2(FLASH_FRAMES + 1);
  localparam int STRIP_W   = 8 * NUM_DIGIT;

  // Panel tile map: diagonal stripe of tile ids; ids beyond the ROM fall back to tile 0.
  function automatic int map_tile(input int tx, input int ty);
    int raw;
    raw = (tx + 2 * ty) % 5;
    return (raw >= NUM_TILES) ? 0 : raw;
  endfunction

  // Tile images: 1-pixel frame on the top/left edge, 8x8 checker inside.
  function automatic logic [7:0] tile_pixel(input logic [ADDR_W-1:0] addr);
    int a, id, r, c;
    a  = int'(addr);
    id = a / (TILE_WIDTH * TILE_WIDTH);
    r  = (a / TILE_WIDTH) % TILE_WIDTH;
    c  = a % TILE_WIDTH;
    if (r == 0 || c == 0) return 8'(20 + id);
    return 8'(32 + id * 8 + (((r >> 3) ^ (c >> 3)) & 1));
  endfunction

  // 8x16 digit font row, MSB = leftmost pixel; seven-segment glyphs in cols 1..6, rows 2..13.
  function automatic logic [7:0] font_row(input logic [3:0] dig, input int row);
    logic [6:0] seg;
    logic [7:0] bits;
    case (dig)
      4'd0: seg = 7'b1111110;
      4'd1: seg = 7'b0110000;
      4'd2: seg = 7'b1101101;
      4'd3: seg = 7'b1111001;
      4'd4: seg = 7'b0110011;
      4'd5: seg = 7'b1011011;
      4'd6: seg = 7'b1011111;
      4'd7: seg = 7'b1110000;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    bits = 8'h00;
    if (row == 2  && seg[6]) bits |= 8'h7E;
    if (row == 7  && seg[0]) bits |= 8'h7E;
    if (row == 13 && seg[3]) bits |= 8'h7E;
    if (row >= 2 && row <= 7) begin
      if (seg[1]) bits |= 8'h40;
      if (seg[5]) bits |= 8'h02;
    end
    if (row >= 7 && row <= 13) begin
      if (seg[2]) bits |= 8'h40;
      if (seg[4]) bits |= 8'h02;
    end
    return bits;
  endfunction

  // Frame pulse synchroniser and registered rising-edge tick
  logic sync1_reg, sync2_reg, sync3_reg, tick_reg;

  always_ff @(posedge CLK or posedge RESET_H) begin
    if (RESET_H) begin
      {sync1_reg, sync2_reg, sync3_reg, tick_reg} <= '0;
    end else begin
      sync1_reg <= FRAME_CLK;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
      tick_reg  <= sync2_reg & ~sync3_reg;
    end
  end

  logic [13:0]     tgt       [NUM_CH];
  logic [13:0]     disp_reg  [NUM_CH];
  logic [13:0]     last_reg  [NUM_CH];
  logic [FL_W-1:0] flash_reg [NUM_CH];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      tgt[i] = (ValueArr[i] > 14'(MAX_VALUE)) ? 14'(MAX_VALUE) : ValueArr[i];
  end

  always_ff @(posedge CLK or posedge RESET_H) begin
    if (RESET_H) begin
      for (int i = 0; i < NUM_CH; i++) begin
        disp_reg[i]  <= '0;
        last_reg[i]  <= '0;
        flash_reg[i] <= '0;
      end
    end else if (tick_reg) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (disp_reg[i] < tgt[i])
          disp_reg[i] <= (tgt[i] - disp_reg[i] > 14'(STEP)) ? disp_reg[i] + 14'(STEP) : tgt[i];
        else if (disp_reg[i] > tgt[i])
          disp_reg[i] <= (disp_reg[i] - tgt[i] > 14'(STEP)) ? disp_reg[i] - 14'(STEP) : tgt[i];
        if (tgt[i] != last_reg[i]) begin
          flash_reg[i] <= FL_W'(FLASH_FRAMES);
          last_reg[i]  <= tgt[i];
        end else if (flash_reg[i] != '0) begin
          flash_reg[i] <= flash_reg[i] - FL_W'(1);
        end
      end
    end
  end

  // Double-dabble converter: one channel per LOAD/SHIFT/NEXT round, all committed together
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_NEXT, S_COMMIT} state_t;
  state_t state_reg, state_next;

  logic [13:0]      bin_reg;
  logic [BCD_W-1:0] work_reg, work_adj;
  logic [3:0]       cnt_reg;
  logic [CH_W-1:0]  ch_reg;
  logic [BCD_W-1:0] shadow_reg [NUM_CH];
  logic [BCD_W-1:0] bcd_reg    [NUM_CH];
  logic             pending_reg, start;
  logic             load_en, shift_en, next_en, commit_en, busy;

  assign start = tick_reg | pending_reg;

  always_ff @(posedge CLK or posedge RESET_H) begin
    if (RESET_H) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_LOAD;
      S_LOAD:   state_next = S_SHIFT;
      S_SHIFT:  if (cnt_reg == 4'd13) state_next = S_NEXT;
      S_NEXT:   state_next = (ch_reg == CH_W'(NUM_CH - 1)) ? S_COMMIT : S_LOAD;
      S_COMMIT: state_next = start ? S_LOAD : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    load_en   = (state_reg == S_LOAD);
    shift_en  = (state_reg == S_SHIFT);
    next_en   = (state_reg == S_NEXT);
    commit_en = (state_reg == S_COMMIT);
    busy      = (state_reg != S_IDLE) && (state_reg != S_COMMIT);
  end

  always_comb begin
    work_adj = work_reg;
    for (int d = 0; d < NUM_DIGIT; d++)
      if (work_reg[4*d +: 4] >= 4'd5) work_adj[4*d +: 4] = work_reg[4*d +: 4] + 4'd3;
  end

  always_ff @(posedge CLK or posedge RESET_H) begin
    if (RESET_H) begin
      bin_reg     <= '0;
      work_reg    <= '0;
      cnt_reg     <= '0;
      ch_reg      <= '0;
      pending_reg <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_reg[i] <= '0;
        bcd_reg[i]    <= '0;
      end
    end else begin
      if (load_en) begin
        bin_reg  <= disp_reg[ch_reg];
        work_reg <= '0;
        cnt_reg  <= '0;
      end
      if (shift_en) begin
        work_reg <= (work_adj << 1) | BCD_W'(bin_reg[13]);
        bin_reg  <= bin_reg << 1;
        cnt_reg  <= cnt_reg + 4'd1;
      end
      if (next_en) begin
        shadow_reg[ch_reg] <= work_reg;
        ch_reg <= (ch_reg == CH_W'(NUM_CH - 1)) ? '0 : ch_reg + CH_W'(1);
      end
      if (commit_en)
        for (int i = 0; i < NUM_CH; i++) bcd_reg[i] <= shadow_reg[i];
      // A tick seen while a pass is running queues exactly one further pass
      if (tick_reg && busy)  pending_reg <= 1'b1;
      else if (commit_en)    pending_reg <= 1'b0;
    end
  end

  // Pixel stage 0: panel-relative coordinates, tile address and digit hit
  logic [9:0]        rx, ry;
  logic              in_panel_s0, hit_s0, flash_s0;
  logic [ADDR_W-1:0] addr_s0;
  logic [NUM_CH-1:0] row_hit;
  int                tile_id, dx, d_idx, row;
  logic [BCD_W-1:0]  upper;

  assign rx = DrawX - COOR[9:0];
  assign ry = DrawY - COOR[19:10];
  assign in_panel_s0 = (DrawX >= COOR[9:0])  && (int'(rx) < PANEL_W) &&
                       (DrawY >= COOR[19:10]) && (int'(ry) < PANEL_H);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_row
    localparam int Y_TOP = DIGIT_Y0 + gi * ROW_PITCH;
    assign row_hit[gi] = (int'(ry) >= Y_TOP) && (int'(ry) < Y_TOP + 16);
  end

  always_comb begin
    tile_id = map_tile(int'(rx) >> TW_BITS, int'(ry) >> TW_BITS);
    addr_s0 = ADDR_W'(tile_id * TILE_WIDTH * TILE_WIDTH +
                      (int'(ry) % TILE_WIDTH) * TILE_WIDTH + (int'(rx) % TILE_WIDTH));
  end

  always_comb begin
    hit_s0   = 1'b0;
    flash_s0 = 1'b0;
    dx       = int'(rx) - DIGIT_X0;
    d_idx    = dx >> 3;
    row      = 0;
    upper    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (row_hit[i] && dx >= 0 && dx < STRIP_W) begin
        row   = int'(ry) - (DIGIT_Y0 + i * ROW_PITCH);
        // Digits at and above d_idx; all-zero means a leading zero unless it is the last digit
        upper = bcd_reg[i] >> (4 * (NUM_DIGIT - 1 - d_idx));
        if ((d_idx == NUM_DIGIT - 1 || upper != '0) && font_row(upper[3:0], row)[7 - (dx & 7)]) begin
          hit_s0   = 1'b1;
          flash_s0 = (flash_reg[i] != '0);
        end
      end
    end
  end

  // Stage 1 (tile ROM read + side-band) and registered output
  logic [7:0] tile_pix_reg, color_reg;
  logic       in_panel_reg, hit_reg, flash_hit_reg;

  always_ff @(posedge CLK or posedge RESET_H) begin
    if (RESET_H) begin
      tile_pix_reg  <= '0;
      in_panel_reg  <= 1'b0;
      hit_reg       <= 1'b0;
      flash_hit_reg <= 1'b0;
      color_reg     <= '0;
    end else begin
      tile_pix_reg  <= tile_pixel(addr_s0);
      in_panel_reg  <= in_panel_s0;
      hit_reg       <= hit_s0;
      flash_hit_reg <= flash_s0;
      if (!in_panel_reg) color_reg <= '0;
      else if (hit_reg)  color_reg <= flash_hit_reg ? FLASH_COLOR : DIGIT_COLOR;
      else               color_reg <= tile_pix_reg;
    end
  end

  assign COLOR_ID = color_reg;

endmodule

// File: tb/tb_attribute_panel_renderer.sv
// Directed bench for attribute_panel_renderer: reset, animation, clamp, flash,
// pixel edge timing, leading-zero blanking and tick overlap during conversion.
module tb_attribute_panel_renderer;

  logic             CLK = 1'b0;
  logic             RESET_H = 1'b0;
  logic             FRAME_CLK = 1'b0;
  logic [9:0]       DrawX = '0;
  logic [9:0]       DrawY = '0;
  logic [4:0][13:0] ValueArr = '0;
  logic [7:0]       COLOR_ID;

  int n_cmp = 0;
  int n_err = 0;
  int n_commit = 0;
  logic cnt_en = 1'b0;

  attribute_panel_renderer dut (
    .CLK(CLK), .RESET_H(RESET_H), .FRAME_CLK(FRAME_CLK),
    .DrawX(DrawX), .DrawY(DrawY), .ValueArr(ValueArr), .COLOR_ID(COLOR_ID)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (cnt_en && dut.commit_en) n_commit++;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic frame_tick(input int hi, input int lo);
    FRAME_CLK = 1'b1;
    repeat (hi) @(posedge CLK);
    #1 FRAME_CLK = 1'b0;
    repeat (lo) @(posedge CLK);
    #1;
  endtask

  task automatic read_pix(input int x, input int y, output int c);
    DrawX = 10'(x);
    DrawY = 10'(y);
    repeat (2) @(posedge CLK);
    #1 c = int'(COLOR_ID);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int xs[4]    = '{31, 32, 223, 224};
    int exp_c[4] = '{0, 22, 49, 0};
    int obs[6];
    int exp_up[5] = '{16, 24, 32, 37, 37};

    #1 RESET_H = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RESET_H = 0;

    // Reset state: blank leading digit shows the tile, then async reset clears output at once
    read_pix(73, 45, c);   check_val("blank_msd_tile", c, 40);
    @(negedge CLK) RESET_H = 1'b1;
    #1 check_val("async_reset_color", COLOR_ID, 0);
    @(posedge CLK);
    #1 RESET_H = 1'b0;
    read_pix(97, 45, c);   check_val("zero_ch0", c, 15);
    read_pix(97, 173, c);  check_val("zero_ch4", c, 15);

    // Panel edge sweep, one pixel per cycle, output exactly 2 cycles later
    DrawY = 10'd68;
    for (int k = 0; k < 6; k++) begin
      obs[k] = int'(COLOR_ID);
      if (k < 4) DrawX = 10'(xs[k]);
      @(posedge CLK);
      #1;
    end
    for (int k = 0; k < 4; k++) check_val($sformatf("edge_x%0d", xs[k]), obs[k+2], exp_c[k]);

    // Animation up: tick latency then 8,16,24,32,37,37
    ValueArr[0] = 14'd37;
    FRAME_CLK = 1'b1;
    repeat (3) @(posedge CLK);
    #1 check_val("tick_not_yet", dut.disp_reg[0], 0);
    @(posedge CLK);
    #1 check_val("anim_t1", dut.disp_reg[0], 8);
    check_val("flash0_set", dut.flash_reg[0], 8);
    FRAME_CLK = 1'b0;
    repeat (100) @(posedge CLK);
    #1;
    for (int t = 0; t < 5; t++) begin
      frame_tick(4, 100);
      check_val($sformatf("anim_t%0d", t + 2), dut.disp_reg[0], exp_up[t]);
    end
    check_val("bcd0_37", dut.bcd_reg[0], 32'h0037);
    read_pix(102, 45, c);  check_val("ch0_7_flash", c, 12);
    read_pix(81, 45, c);   check_val("ch0_blank_d1", c, 41);

    // Animation down in one step
    ValueArr[0] = 14'd30;
    frame_tick(4, 100);
    check_val("anim_down", dut.disp_reg[0], 30);
    check_val("flash0_reset", dut.flash_reg[0], 8);

    // Clamp: fast ticks, converter kept busy throughout
    ValueArr[2] = 14'd12000;
    for (int t = 0; t < 1260; t++) frame_tick(4, 4);
    repeat (200) @(posedge CLK);
    #1;
    check_val("clamp_disp2", dut.disp_reg[2], 9999);
    check_val("clamp_bcd2", dut.bcd_reg[2], 32'h9999);
    check_val("clamp_flash2", dut.flash_reg[2], 0);
    read_pix(73, 109, c);  check_val("ch2_msd_9", c, 15);

    // Flash: channel 1 flashes for ticks k..k+7, steady from k+8
    ValueArr[1] = 14'd5;
    frame_tick(4, 100);
    check_val("disp1_5", dut.disp_reg[1], 5);
    read_pix(97, 77, c);   check_val("flash_k", c, 12);
    read_pix(97, 45, c);   check_val("ch0_unaffected", c, 15);
    for (int t = 0; t < 7; t++) frame_tick(4, 100);
    read_pix(97, 77, c);   check_val("flash_k7", c, 12);
    frame_tick(4, 100);
    read_pix(97, 77, c);   check_val("flash_k8", c, 15);

    // Tick overlap: second tick mid-pass queues exactly one extra pass
    ValueArr[3] = 14'd7;
    n_commit = 0;
    cnt_en = 1'b1;
    frame_tick(4, 6);
    frame_tick(4, 250);
    cnt_en = 1'b0;
    check_val("pending_passes", n_commit, 2);
    check_val("disp3_7", dut.disp_reg[3], 7);
    check_val("bcd3_7", dut.bcd_reg[3], 32'h0007);
    read_pix(102, 141, c); check_val("ch3_7_hit", c, 12);
    read_pix(97, 141, c);  check_val("ch3_7_gap", c, 57);
    read_pix(94, 141, c);  check_val("ch3_lead_blank", c, 48);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
